axi_str_fifo: RTL and testbench
===============================

AXI_STR_FIFO -- requirements
Module: axi_str_fifo

Interface
REQ-001 Parameter: DATA_SIZE, default 32, tdata width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter: USER_SIZE, default 16, tuser width in bits; minimum 1.
REQ-003 Parameter: DEPTH, default 16, entry count; SHALL be a power of 2, minimum 2.
REQ-004 Parameter: PKT_MODE, default 0; 0 = cut-through, 1 = store-and-forward.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-007 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port: s_tvalid, input, 1, slave-side beat valid.
REQ-009 Port: s_tready, output, 1, slave-side ready.
REQ-010 Port: s_tdata, input, DATA_SIZE, slave-side data.
REQ-011 Port: s_tkeep, input, DATA_SIZE/8, slave-side byte qualifiers.
REQ-012 Port: s_tuser, input, USER_SIZE, slave-side sideband.
REQ-013 Port: s_tlast, input, 1, slave-side end of packet.
REQ-014 Port: m_tvalid, m_tready, m_tdata, m_tkeep, m_tuser, m_tlast: output, input, output, output, output, output respectively; widths mirror the s_* ports; master-side stream.
REQ-015 Port: count, output, $clog2(DEPTH)+1, number of stored beats.
REQ-016 Port: pkt_count, output, $clog2(DEPTH)+1, number of stored beats with tlast=1.

Function
REQ-017 Push occurs when s_tvalid && s_tready at a clock edge; the whole beat (tdata, tkeep, tuser, tlast) SHALL be stored as one entry.
REQ-018 Pop occurs when m_tvalid && m_tready at a clock edge.
REQ-019 Storage: circular buffer, write and read pointers $clog2(DEPTH) bits each, wrapping DEPTH-1 -> 0 with no gap.
REQ-020 s_tready SHALL be registered and equal (count < DEPTH), i.e. ready only when not full; no combinational path from m_tready to s_tready.
REQ-021 Full and pop in the same cycle: no push (s_tready=0); count decrements by 1.
REQ-022 Beat latency: a beat pushed at edge N into an empty FIFO SHALL appear on m_* with m_tvalid=1 no earlier than edge N+1; there is no combinational bypass from s_* to m_*.
REQ-023 PKT_MODE=0: m_tvalid SHALL be 1 whenever count > 0.
REQ-024 PKT_MODE=1: m_tvalid SHALL be 1 when count > 0 and either pkt_count > 0 or count == DEPTH (full fallback to cut-through to avoid deadlock on oversize packets).
REQ-025 PKT_MODE=1: once the first beat of a packet has been popped, m_tvalid SHALL remain asserted while count > 0 until that packet's tlast beat has popped.
REQ-026 While m_tvalid=1 and m_tready=0, the m_* payload SHALL hold stable.
REQ-027 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-028 pkt_count: +1 on push with s_tlast=1, -1 on pop with m_tlast=1; a simultaneous push and pop, each with tlast=1, SHALL leave it unchanged.
REQ-029 m_tdata, m_tkeep and m_tuser SHALL be passed through unmodified; the block SHALL NOT interpret tkeep.

Reset
REQ-030 While reset_n=0: pointers=0, count=0, pkt_count=0, m_tvalid=0, s_tready=0, and the packet-in-progress flag is cleared.
REQ-031 At the first edge with reset_n=1, s_tready SHALL go to 1; m_* payload contents are don't-care while m_tvalid=0.
REQ-032 Reset asserted mid-packet SHALL discard all stored beats; no partial packet SHALL be emitted after release.

Verification
REQ-033 Default parameters, PKT_MODE=0, m_tready=1: push 0xA0..0xA3 on consecutive cycles -> m_tdata is 0xA0..0xA3 in order, the first one cycle after its push, and count never exceeds 1.
REQ-034 DEPTH=4, m_tready=0: push 5 beats -> s_tready=0 after the 4th, count=4; then m_tready=1 for one cycle -> count=3 and s_tready=1 on the next cycle.
REQ-035 PKT_MODE=1: push 3 beats with tlast only on the 3rd -> m_tvalid=0 until the edge after the tlast push, then 3 beats are emitted back-to-back and pkt_count goes 1 -> 0.
REQ-036 PKT_MODE=1, DEPTH=4: push 6 beats with no tlast -> m_tvalid=1 once count=4, and all 6 beats drain in order.
REQ-037 Wrap-around with random s_tvalid/m_tready over 1000 beats with random tkeep/tuser -> output sequence identical to input, and count matches a scoreboard every cycle.
REQ-038 Assert reset_n=0 with count=3 mid-packet -> m_tvalid=0 immediately, count=0 and pkt_count=0, and the first beat output after release is the first beat pushed after release.

Source files
------------

// File: rtl/axi_str_fifo.sv
// AXI4-Stream FIFO: circular buffer of full beats (tdata/tkeep/tuser/tlast) with
// optional store-and-forward gating of the master side on complete packets.
module axi_str_fifo #(
    parameter int DATA_SIZE = 32,
    parameter int USER_SIZE = 16,
    parameter int DEPTH     = 16,
    parameter int PKT_MODE  = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_SIZE-1:0]      s_tdata,
    input  logic [DATA_SIZE/8-1:0]    s_tkeep,
    input  logic [USER_SIZE-1:0]      s_tuser,
    input  logic                      s_tlast,

    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_SIZE-1:0]      m_tdata,
    output logic [DATA_SIZE/8-1:0]    m_tkeep,
    output logic [USER_SIZE-1:0]      m_tuser,
    output logic                      m_tlast,

    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = DATA_SIZE / 8;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if ((DATA_SIZE % 8) != 0 || DATA_SIZE < 8) begin : g_bad_data_size
        $error("axi_str_fifo: DATA_SIZE must be a non-zero multiple of 8");
    end
    if (USER_SIZE < 1) begin : g_bad_user_size
        $error("axi_str_fifo: USER_SIZE must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axi_str_fifo: DEPTH must be a power of 2, at least 2");
    end

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic [KW-1:0]        keep;
        logic [USER_SIZE-1:0] user;
        logic                 last;
    } beat_t;

    beat_t           mem_q [DEPTH];
    beat_t           rd_beat;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   pkt_count_q, pkt_count_d;
    logic            s_tready_q, s_tready_d;
    // Set between popping the first and the tlast beat of a packet.
    logic            in_pkt_q, in_pkt_d;

    logic            push, pop;
    logic            pkt_inc, pkt_dec;

    assign push    = s_tvalid && s_tready_q;
    assign pop     = m_tvalid && m_tready;
    assign rd_beat = mem_q[rd_ptr_q];

    // Store-and-forward releases a beat only for a complete packet, a full
    // buffer (oversize packet) or the remainder of a packet already started.
    always_comb begin
        m_tvalid = (count_q != '0);
        if (PKT_MODE != 0) begin
            m_tvalid = (count_q != '0) &&
                       ((pkt_count_q != '0) || (count_q == FULL_CNT) || in_pkt_q);
        end
    end

    assign pkt_inc = push && s_tlast;
    assign pkt_dec = pop && rd_beat.last;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pkt_count_d = pkt_count_q;
        in_pkt_d    = in_pkt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            in_pkt_d = !rd_beat.last;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase

        s_tready_d = (count_d < FULL_CNT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            in_pkt_q    <= 1'b0;
            s_tready_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            in_pkt_q    <= in_pkt_d;
            s_tready_q  <= s_tready_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are only
    // observed while m_tvalid is high, which needs a prior write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{data: s_tdata, keep: s_tkeep, user: s_tuser, last: s_tlast};
        end
    end

    assign s_tready  = s_tready_q;
    assign m_tdata   = rd_beat.data;
    assign m_tkeep   = rd_beat.keep;
    assign m_tuser   = rd_beat.user;
    assign m_tlast   = rd_beat.last;
    assign count     = count_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axi_str_fifo.sv
// Bench for axi_str_fifo: three instances (cut-through D16, cut-through D4,
// store-and-forward D4) checked against a per-instance beat scoreboard.
module tb_axi_str_fifo;

    localparam int NI = 3;
    localparam int DW = 32;
    localparam int UW = 16;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk;
    logic          reset_n;

    logic          s_tvalid [NI];
    logic [DW-1:0] s_tdata  [NI];
    logic [KW-1:0] s_tkeep  [NI];
    logic [UW-1:0] s_tuser  [NI];
    logic          s_tlast  [NI];
    logic          m_tready [NI];

    wire logic          s_tready  [NI];
    wire logic          m_tvalid  [NI];
    wire logic [DW-1:0] m_tdata   [NI];
    wire logic [KW-1:0] m_tkeep   [NI];
    wire logic [UW-1:0] m_tuser   [NI];
    wire logic          m_tlast   [NI];
    wire logic [4:0]    count     [NI];
    wire logic [4:0]    pkt_count [NI];

    int    errors = 0;
    int    checks = 0;
    beat_t sb [NI][$];
    bit    mdl_inpkt [NI];
    bit    live [NI];
    int    pop_cnt [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = (g == 0) ? 16 : 4;
        localparam int CW = $clog2(D) + 1;
        logic [CW-1:0] cnt;
        logic [CW-1:0] pcnt;

        axi_str_fifo #(
            .DATA_SIZE(DW), .USER_SIZE(UW), .DEPTH(D), .PKT_MODE((g == 2) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .s_tvalid (s_tvalid[g]),
            .s_tready (s_tready[g]),
            .s_tdata  (s_tdata[g]),
            .s_tkeep  (s_tkeep[g]),
            .s_tuser  (s_tuser[g]),
            .s_tlast  (s_tlast[g]),
            .m_tvalid (m_tvalid[g]),
            .m_tready (m_tready[g]),
            .m_tdata  (m_tdata[g]),
            .m_tkeep  (m_tkeep[g]),
            .m_tuser  (m_tuser[g]),
            .m_tlast  (m_tlast[g]),
            .count    (cnt),
            .pkt_count(pcnt)
        );

        assign count[g]     = 5'(cnt);
        assign pkt_count[g] = 5'(pcnt);
    end

    function automatic int dep_of(input int d);
        return (d == 0) ? 16 : 4;
    endfunction

    function automatic bit pkt_of(input int d);
        return d == 2;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < NI; d++) live[d] = 1'b1;
        end
    end

    // Scoreboard monitor: sampled mid-cycle, once inputs and outputs have settled
    // for the coming rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int d = 0; d < NI; d++) begin
                sb[d].delete();
                mdl_inpkt[d] = 1'b0;
                live[d]      = 1'b0;
            end
        end else begin
            for (int d = 0; d < NI; d++) begin
                int    n;
                int    nl;
                bit    exp_mv;
                beat_t got;
                beat_t exp;
                n  = sb[d].size();
                nl = 0;
                for (int j = 0; j < n; j++) if (sb[d][j].last) nl++;

                checks++;
                if (count[d] !== 5'(n)) begin
                    errors++;
                    $display("FAIL count inst%0d: got %0d expected %0d", d, count[d], n);
                end
                checks++;
                if (pkt_count[d] !== 5'(nl)) begin
                    errors++;
                    $display("FAIL pkt_count inst%0d: got %0d expected %0d", d, pkt_count[d], nl);
                end
                if (live[d]) begin
                    checks++;
                    if (s_tready[d] !== (n < dep_of(d))) begin
                        errors++;
                        $display("FAIL s_tready inst%0d: got %b expected %b", d, s_tready[d], n < dep_of(d));
                    end
                end
                exp_mv = (n > 0) && (!pkt_of(d) || nl > 0 || n == dep_of(d) || mdl_inpkt[d]);
                checks++;
                if (m_tvalid[d] !== exp_mv) begin
                    errors++;
                    $display("FAIL m_tvalid inst%0d: got %b expected %b", d, m_tvalid[d], exp_mv);
                end

                if (m_tvalid[d] === 1'b1 && m_tready[d] && n > 0) begin
                    exp = sb[d].pop_front();
                    got = '{data: m_tdata[d], keep: m_tkeep[d], user: m_tuser[d], last: m_tlast[d]};
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL beat inst%0d: got %h expected %h", d, got, exp);
                    end
                    mdl_inpkt[d] = !exp.last;
                    pop_cnt[d]++;
                end
                if (s_tvalid[d] && s_tready[d] === 1'b1) begin
                    sb[d].push_back('{data: s_tdata[d], keep: s_tkeep[d],
                                      user: s_tuser[d], last: s_tlast[d]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int d, input logic [DW-1:0] data, input logic [KW-1:0] keep,
                             input logic [UW-1:0] user, input logic last);
        bit hs;
        int cyc;
        cyc = 0;
        s_tvalid[d] = 1'b1;
        s_tdata[d]  = data;
        s_tkeep[d]  = keep;
        s_tuser[d]  = user;
        s_tlast[d]  = last;
        do begin
            hs = s_tready[d];
            tick();
            cyc++;
        end while (!hs && cyc < 200);
        s_tvalid[d] = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL push_timeout inst%0d: s_tready low for %0d cycles, expected 1", d, cyc);
        end
    endtask

    task automatic wait_drain(input int d);
        int cyc;
        cyc = 0;
        while (count[d] !== 5'd0 && cyc < 500) begin
            tick();
            cyc++;
        end
        checks++;
        if (count[d] !== 5'd0) begin
            errors++;
            $display("FAIL drain_timeout inst%0d: count %0d expected 0", d, count[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (m_tvalid[d] !== 1'b0 || s_tready[d] !== 1'b0 || count[d] !== 5'd0 ||
                pkt_count[d] !== 5'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: vld=%b rdy=%b cnt=%0d pcnt=%0d expected 0 0 0 0",
                         d, m_tvalid[d], s_tready[d], count[d], pkt_count[d]);
            end
        end
        reset_n = 1'b1;
        tick();
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (s_tready[d] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset inst%0d: got %b expected 1", d, s_tready[d]);
            end
        end
    endtask

    task automatic test_cut_through();
        m_tready[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_beat(0, DW'(32'hA0 + k), 4'hF, UW'(k), k == 3);
            checks++;
            if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== DW'(32'hA0 + k)) begin
                errors++;
                $display("FAIL ct_latency beat%0d: vld=%b data=%h expected 1 %h",
                         k, m_tvalid[0], m_tdata[0], 32'hA0 + k);
            end
            checks++;
            if (count[0] !== 5'd1) begin
                errors++;
                $display("FAIL ct_count beat%0d: got %0d expected 1", k, count[0]);
            end
        end
        tick();
        checks++;
        if (count[0] !== 5'd0 || m_tvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ct_empty: cnt=%0d vld=%b expected 0 0", count[0], m_tvalid[0]);
        end
        m_tready[0] = 1'b0;
    endtask

    task automatic test_full();
        m_tready[1] = 1'b0;
        for (int k = 0; k < 4; k++) push_beat(1, DW'(32'hB0 + k), 4'(k), UW'(16'h100 + k), 1'b0);
        checks++;
        if (count[1] !== 5'd4 || s_tready[1] !== 1'b0) begin
            errors++;
            $display("FAIL full_state: cnt=%0d rdy=%b expected 4 0", count[1], s_tready[1]);
        end
        s_tvalid[1] = 1'b1;
        s_tdata[1]  = 32'hB4;
        s_tkeep[1]  = 4'h4;
        s_tuser[1]  = 16'h104;
        s_tlast[1]  = 1'b1;
        tick();
        tick();
        checks++;
        if (count[1] !== 5'd4 || s_tready[1] !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: cnt=%0d rdy=%b expected 4 0", count[1], s_tready[1]);
        end
        m_tready[1] = 1'b1;
        tick();
        m_tready[1] = 1'b0;
        checks++;
        if (count[1] !== 5'd3 || s_tready[1] !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: cnt=%0d rdy=%b expected 3 1", count[1], s_tready[1]);
        end
        tick();
        s_tvalid[1] = 1'b0;
        checks++;
        if (count[1] !== 5'd4) begin
            errors++;
            $display("FAIL full_refill: cnt=%0d expected 4", count[1]);
        end
        m_tready[1] = 1'b1;
        wait_drain(1);
        m_tready[1] = 1'b0;
    endtask

    task automatic test_pkt();
        m_tready[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_beat(2, DW'(32'hD0 + k), 4'hF, UW'(16'h200 + k), k == 2);
            checks++;
            if (m_tvalid[2] !== (k == 2)) begin
                errors++;
                $display("FAIL pkt_gate beat%0d: vld=%b expected %b", k, m_tvalid[2], k == 2);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_tvalid[2] !== 1'b1 || m_tdata[2] !== DW'(32'hD0 + k) ||
                count[2] !== 5'(3 - k) || pkt_count[2] !== 5'd1) begin
                errors++;
                $display("FAIL pkt_emit beat%0d: vld=%b data=%h cnt=%0d pcnt=%0d expected 1 %h %0d 1",
                         k, m_tvalid[2], m_tdata[2], count[2], pkt_count[2], 32'hD0 + k, 3 - k);
            end
            tick();
        end
        checks++;
        if (count[2] !== 5'd0 || pkt_count[2] !== 5'd0 || m_tvalid[2] !== 1'b0) begin
            errors++;
            $display("FAIL pkt_done: cnt=%0d pcnt=%0d vld=%b expected 0 0 0",
                     count[2], pkt_count[2], m_tvalid[2]);
        end
        m_tready[2] = 1'b0;
    endtask

    task automatic test_oversize();
        m_tready[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_beat(2, DW'(32'hE0 + k), 4'(k), UW'(16'h300 + k), 1'b0);
            if (k < 3) begin
                checks++;
                if (m_tvalid[2] !== 1'b0 || count[2] !== 5'(k + 1)) begin
                    errors++;
                    $display("FAIL oversize_gate beat%0d: vld=%b cnt=%0d expected 0 %0d",
                             k, m_tvalid[2], count[2], k + 1);
                end
            end else if (k == 3) begin
                checks++;
                if (m_tvalid[2] !== 1'b1 || count[2] !== 5'd4) begin
                    errors++;
                    $display("FAIL oversize_full: vld=%b cnt=%0d expected 1 4", m_tvalid[2], count[2]);
                end
            end
        end
        wait_drain(2);
        m_tready[2] = 1'b0;
    endtask

    task automatic test_random(input int d);
        int target;
        target = pop_cnt[d] + 1000;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_beat(d, DW'($urandom), KW'($urandom), UW'($urandom),
                              (k == 999) || ($urandom_range(0, 3) == 0));
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (pop_cnt[d] < target && cyc < 20000) begin
                    m_tready[d] = 1'($urandom_range(0, 1));
                    tick();
                    cyc++;
                end
                m_tready[d] = 1'b0;
            end
        join
        checks++;
        if (pop_cnt[d] != target) begin
            errors++;
            $display("FAIL random_pops inst%0d: got %0d expected %0d", d, pop_cnt[d], target);
        end
    endtask

    task automatic test_mid_reset();
        m_tready[0] = 1'b0;
        for (int k = 0; k < 3; k++) push_beat(0, DW'(32'hF0 + k), 4'hF, 16'h0, 1'b0);
        m_tready[2] = 1'b0;
        for (int k = 0; k < 4; k++) push_beat(2, DW'(32'hF8 + k), 4'hF, 16'h0, 1'b0);
        m_tready[2] = 1'b1;
        tick();
        m_tready[2] = 1'b0;
        checks++;
        if (count[2] !== 5'd3 || m_tvalid[2] !== 1'b1 || count[0] !== 5'd3) begin
            errors++;
            $display("FAIL midpkt_setup: cnt2=%0d vld2=%b cnt0=%0d expected 3 1 3",
                     count[2], m_tvalid[2], count[0]);
        end
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (m_tvalid[d] !== 1'b0 || count[d] !== 5'd0 || pkt_count[d] !== 5'd0 ||
                s_tready[d] !== 1'b0) begin
                errors++;
                $display("FAIL midreset inst%0d: vld=%b cnt=%0d pcnt=%0d rdy=%b expected 0 0 0 0",
                         d, m_tvalid[d], count[d], pkt_count[d], s_tready[d]);
            end
            sb[d].delete();
            mdl_inpkt[d] = 1'b0;
            live[d]      = 1'b0;
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        m_tready[2] = 1'b1;
        push_beat(2, 32'h1234_0000, 4'h3, 16'hAAAA, 1'b0);
        checks++;
        if (m_tvalid[2] !== 1'b0) begin
            errors++;
            $display("FAIL postreset_partial: vld=%b expected 0", m_tvalid[2]);
        end
        push_beat(2, 32'h1234_0001, 4'hC, 16'h5555, 1'b1);
        checks++;
        if (m_tvalid[2] !== 1'b1 || m_tdata[2] !== 32'h1234_0000) begin
            errors++;
            $display("FAIL postreset_first: vld=%b data=%h expected 1 12340000", m_tvalid[2], m_tdata[2]);
        end
        wait_drain(2);
        m_tready[0] = 1'b1;
        push_beat(0, 32'h5678_0000, 4'h1, 16'h0001, 1'b0);
        checks++;
        if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 32'h5678_0000) begin
            errors++;
            $display("FAIL postreset_ct: vld=%b data=%h expected 1 56780000", m_tvalid[0], m_tdata[0]);
        end
        wait_drain(0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < NI; d++) begin
            s_tvalid[d]  = 1'b0;
            s_tdata[d]   = '0;
            s_tkeep[d]   = '0;
            s_tuser[d]   = '0;
            s_tlast[d]   = 1'b0;
            m_tready[d]  = 1'b0;
            mdl_inpkt[d] = 1'b0;
            live[d]      = 1'b0;
            pop_cnt[d]   = 0;
        end
        repeat (3) tick();
        test_reset();
        test_cut_through();
        test_full();
        test_pkt();
        test_oversize();
        for (int d = 0; d < NI; d++) test_random(d);
        test_mid_reset();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
